// File: rtl/axi_rom_pkg.sv
// rtl/axi_rom_pkg.sv - shared constants and state types for the instruction ROM responder
package axi_rom_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_LAT   = 2'd1,
        R_BURST = 2'd2
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wr_state_t;

endpackage

// File: rtl/axi_inst_rom_slave_if.sv
// rtl/axi_inst_rom_slave_if.sv - AXI3 bus bundle between an instruction-fetch master and the ROM
interface axi_inst_rom_slave_if;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;

    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [3:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [1:0]  awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;

    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;

    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );
endinterface

// File: rtl/rom_mem_array.sv
// rtl/rom_mem_array.sv - word storage with one synchronous load port and one combinational read port
module rom_mem_array #(
    parameter int IDX_W = 10
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] widx,
    input  logic [31:0]      wdata,
    input  logic [IDX_W-1:0] ridx,
    output logic [31:0]      rdata
);

    logic [31:0] mem [2**IDX_W];

    // No reset: the image survives aresetn so a core can be re-booted without reloading.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[widx] <= wdata;
        end
    end

    assign rdata = mem[ridx];

endmodule

// File: rtl/axi_inst_rom_slave.sv
// rtl/axi_inst_rom_slave.sv - AXI3 read-only instruction memory; writes are answered with SLVERR
module axi_inst_rom_slave
    import axi_rom_pkg::*;
#(
    parameter int IDX_W   = 10,
    parameter int LATENCY = 1
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    axi_inst_rom_slave_if.slave  axi,
    input  logic                 ld_we,
    input  logic [IDX_W-1:0]     ld_idx,
    input  logic [31:0]          ld_data
);

    rd_state_t        rd_state, rd_next;
    wr_state_t        wr_state, wr_next;
    logic [3:0]       lat_cnt, beat_cnt, r_len, r_id, b_id;
    logic [1:0]       r_burst, r_resp;
    logic [IDX_W-1:0] r_idx, ar_idx, step_idx, mem_ridx;
    logic [31:0]      mem_rdata, r_data;
    logic             r_valid, r_last;
    logic             ar_hs, load_first, advance;
    logic [3:0]       first_len;

    assign ar_idx    = axi.araddr[IDX_W+1:2];
    assign step_idx  = (r_burst == BURST_FIXED) ? r_idx : r_idx + 1'b1;
    assign first_len = (rd_state == R_IDLE) ? axi.arlen : r_len;

    // The single read port looks at whichever word the next registered beat needs.
    assign mem_ridx  = (rd_state == R_IDLE) ? ar_idx :
                       (rd_state == R_LAT)  ? r_idx  : step_idx;

    rom_mem_array #(.IDX_W(IDX_W)) u_mem (
        .clk   (aclk),
        .we    (ld_we),
        .widx  (ld_idx),
        .wdata (ld_data),
        .ridx  (mem_ridx),
        .rdata (mem_rdata)
    );

    always_comb begin
        rd_next     = rd_state;
        ar_hs       = 1'b0;
        load_first  = 1'b0;
        advance     = 1'b0;
        axi.arready = 1'b0;
        case (rd_state)
            R_IDLE: begin
                axi.arready = 1'b1;
                if (axi.arvalid) begin
                    ar_hs = 1'b1;
                    if (LATENCY == 1) begin
                        load_first = 1'b1;
                        rd_next    = R_BURST;
                    end else begin
                        rd_next    = R_LAT;
                    end
                end
            end
            R_LAT: begin
                if (lat_cnt == 4'd1) begin
                    load_first = 1'b1;
                    rd_next    = R_BURST;
                end
            end
            R_BURST: begin
                if (r_valid && axi.rready) begin
                    if (r_last) rd_next = R_IDLE;
                    else        advance = 1'b1;
                end
            end
            default: rd_next = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rd_state <= R_IDLE;
            lat_cnt  <= '0;
            beat_cnt <= '0;
            r_len    <= '0;
            r_id     <= '0;
            r_burst  <= '0;
            r_resp   <= RESP_OKAY;
            r_idx    <= '0;
            r_data   <= '0;
            r_valid  <= 1'b0;
            r_last   <= 1'b0;
        end else begin
            rd_state <= rd_next;
            if (ar_hs) begin
                r_id     <= axi.arid;
                r_len    <= axi.arlen;
                r_burst  <= axi.arburst;
                r_resp   <= (axi.arsize != 3'b010) ? RESP_SLVERR : RESP_OKAY;
                r_idx    <= ar_idx;
                lat_cnt  <= 4'(LATENCY - 1);
                beat_cnt <= '0;
            end
            if (rd_state == R_LAT) begin
                lat_cnt <= lat_cnt - 1'b1;
            end
            if (load_first) begin
                r_data  <= mem_rdata;
                r_valid <= 1'b1;
                r_last  <= (first_len == 4'd0);
            end else if (advance) begin
                r_idx    <= step_idx;
                r_data   <= mem_rdata;
                beat_cnt <= beat_cnt + 4'd1;
                r_last   <= ((beat_cnt + 4'd1) == r_len);
            end else if (rd_state == R_BURST && axi.rready && r_last) begin
                r_valid <= 1'b0;
                r_last  <= 1'b0;
            end
        end
    end

    assign axi.rid    = r_id;
    assign axi.rdata  = r_data;
    assign axi.rresp  = r_resp;
    assign axi.rlast  = r_last;
    assign axi.rvalid = r_valid;

    always_comb begin
        wr_next     = wr_state;
        axi.awready = 1'b0;
        axi.wready  = 1'b0;
        axi.bvalid  = 1'b0;
        axi.bresp   = RESP_OKAY;
        case (wr_state)
            W_IDLE: begin
                axi.awready = 1'b1;
                if (axi.awvalid) wr_next = W_DATA;
            end
            W_DATA: begin
                axi.wready = 1'b1;
                if (axi.wvalid && axi.wlast) wr_next = W_RESP;
            end
            W_RESP: begin
                axi.bvalid = 1'b1;
                axi.bresp  = RESP_SLVERR;
                if (axi.bready) wr_next = W_IDLE;
            end
            default: wr_next = W_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_state <= W_IDLE;
            b_id     <= '0;
        end else begin
            wr_state <= wr_next;
            if (wr_state == W_IDLE && axi.awvalid) begin
                b_id <= axi.awid;
            end
        end
    end

    assign axi.bid = b_id;

endmodule

// File: tb/tb_axi_inst_rom_slave.sv
// tb/tb_axi_inst_rom_slave.sv - scoreboard bench driving LATENCY=1 and LATENCY=4 instances in lockstep
module tb_axi_inst_rom_slave;
    import axi_rom_pkg::*;

    localparam int IDX_W = 10;
    localparam int DEPTH = 1 << IDX_W;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
        logic [3:0]  id;
        logic        last;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic             ld_we = 1'b0;
    logic [IDX_W-1:0] ld_idx = '0;
    logic [31:0]      ld_data = '0;

    axi_inst_rom_slave_if a();
    axi_inst_rom_slave_if b();

    axi_inst_rom_slave #(.IDX_W(IDX_W), .LATENCY(1)) dut1 (
        .aclk(clk), .aresetn(rst_n), .axi(a), .ld_we(ld_we), .ld_idx(ld_idx), .ld_data(ld_data));
    axi_inst_rom_slave #(.IDX_W(IDX_W), .LATENCY(4)) dut4 (
        .aclk(clk), .aresetn(rst_n), .axi(b), .ld_we(ld_we), .ld_idx(ld_idx), .ld_data(ld_data));

    assign b.arid = a.arid;       assign b.araddr = a.araddr;   assign b.arlen = a.arlen;
    assign b.arsize = a.arsize;   assign b.arburst = a.arburst; assign b.arlock = a.arlock;
    assign b.arcache = a.arcache; assign b.arprot = a.arprot;   assign b.arvalid = a.arvalid;
    assign b.rready = a.rready;
    assign b.awid = a.awid;       assign b.awaddr = a.awaddr;   assign b.awlen = a.awlen;
    assign b.awsize = a.awsize;   assign b.awburst = a.awburst; assign b.awlock = a.awlock;
    assign b.awcache = a.awcache; assign b.awprot = a.awprot;   assign b.awvalid = a.awvalid;
    assign b.wid = a.wid;         assign b.wdata = a.wdata;     assign b.wstrb = a.wstrb;
    assign b.wlast = a.wlast;     assign b.wvalid = a.wvalid;   assign b.bready = a.bready;

    logic [1:0]  rv, rl, arr, awr, wr, bv;
    logic [31:0] rd [2];
    logic [3:0]  ri [2], bi [2];
    logic [1:0]  rr [2], br [2];
    assign rv  = {b.rvalid, a.rvalid};   assign rl  = {b.rlast, a.rlast};
    assign arr = {b.arready, a.arready}; assign awr = {b.awready, a.awready};
    assign wr  = {b.wready, a.wready};   assign bv  = {b.bvalid, a.bvalid};
    assign rd[0] = a.rdata; assign rd[1] = b.rdata; assign ri[0] = a.rid;   assign ri[1] = b.rid;
    assign rr[0] = a.rresp; assign rr[1] = b.rresp; assign bi[0] = a.bid;   assign bi[1] = b.bid;
    assign br[0] = a.bresp; assign br[1] = b.bresp;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rr_mode = 0;
    int lat_req [2] = '{1, 4};
    int hs_cyc [2];
    bit first_pend [2];
    bit stalled [2];
    beat_t prev [2];
    beat_t q0 [$];
    beat_t q1 [$];
    logic [3:0] bq0 [$];
    logic [3:0] bq1 [$];
    logic [31:0] ref_mem [DEPTH];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Read-side monitor: latency, stall stability and per-beat scoreboard for both instances.
    always @(negedge clk) begin
        beat_t cur, e;
        if (rst_n) begin
            for (int k = 0; k < 2; k++) begin
                cur = {rd[k], rr[k], ri[k], rl[k]};
                if (a.arvalid && arr[k]) begin
                    hs_cyc[k] = cyc;
                    first_pend[k] = 1'b1;
                end
                if (rv[k]) begin
                    if (first_pend[k]) begin
                        chk($sformatf("latency_dut%0d", k), 64'(cyc - hs_cyc[k]), 64'(lat_req[k]));
                        first_pend[k] = 1'b0;
                    end
                    if (stalled[k]) chk($sformatf("stall_hold_dut%0d", k), 64'(cur), 64'(prev[k]));
                    if (a.rready) begin
                        if ((k == 0 ? q0.size() : q1.size()) == 0) begin
                            chk($sformatf("unexpected_beat_dut%0d", k), 64'(cur), 64'd0);
                        end else begin
                            e = (k == 0) ? q0.pop_front() : q1.pop_front();
                            chk($sformatf("beat_dut%0d", k), 64'(cur), 64'(e));
                        end
                    end
                end
                stalled[k] = rv[k] && !a.rready;
                prev[k] = cur;
                if (bv[k] && a.bready) begin
                    if ((k == 0 ? bq0.size() : bq1.size()) == 0) begin
                        chk($sformatf("unexpected_b_dut%0d", k), 64'({bi[k], br[k]}), 64'd0);
                    end else begin
                        chk($sformatf("bresp_dut%0d", k), 64'({bi[k], br[k]}),
                            64'({(k == 0) ? bq0.pop_front() : bq1.pop_front(), RESP_SLVERR}));
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rr_mode)
                0:       a.rready = 1'b1;
                1:       a.rready = ~a.rready;
                default: a.rready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic wait_idle();
        for (int t = 0; t < 3000 && (q0.size() != 0 || q1.size() != 0 || bq0.size() != 0 || bq1.size() != 0); t++)
            @(negedge clk);
        if (q0.size() != 0 || q1.size() != 0 || bq0.size() != 0 || bq1.size() != 0) begin
            chk("drain_timeout", 64'(q0.size() + q1.size() + bq0.size() + bq1.size()), 64'd0);
            q0.delete(); q1.delete(); bq0.delete(); bq1.delete();
        end
    endtask

    task automatic load(input int idx, input logic [31:0] data);
        @(posedge clk); #1;
        ld_we = 1'b1; ld_idx = IDX_W'(idx); ld_data = data;
        @(posedge clk); #1;
        ld_we = 1'b0;
        ref_mem[idx] = data;
    endtask

    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [1:0] burst, input logic [2:0] size);
        int idx;
        beat_t e;
        while (q0.size() != 0 || q1.size() != 0) wait_idle();
        idx = int'(addr >> 2) % DEPTH;
        for (int i = 0; i <= int'(len); i++) begin
            e.data = ref_mem[idx];
            e.resp = (size != 3'b010) ? RESP_SLVERR : RESP_OKAY;
            e.id   = id;
            e.last = (i == int'(len));
            q0.push_back(e);
            q1.push_back(e);
            if (burst != BURST_FIXED) idx = (idx + 1) % DEPTH;
        end
        @(posedge clk); #1;
        a.arid = id; a.araddr = addr; a.arlen = len; a.arburst = burst; a.arsize = size;
        a.arlock = 2'($urandom); a.arcache = 4'($urandom); a.arprot = 3'($urandom);
        a.arvalid = 1'b1;
        @(posedge clk); #1;
        a.arvalid = 1'b0;
        a.araddr = $urandom;
    endtask

    // Load and AR handshake share one edge: the LATENCY=1 instance samples the old word.
    task automatic do_read_collide(input logic [3:0] id, input int idx, input logic [31:0] nv);
        beat_t e;
        wait_idle();
        e = {ref_mem[idx], RESP_OKAY, id, 1'b1};
        q0.push_back(e);
        e.data = nv;
        q1.push_back(e);
        ref_mem[idx] = nv;
        @(posedge clk); #1;
        a.arid = id; a.araddr = 32'(idx * 4); a.arlen = 4'd0; a.arburst = BURST_INCR; a.arsize = 3'b010;
        a.arvalid = 1'b1;
        ld_we = 1'b1; ld_idx = IDX_W'(idx); ld_data = nv;
        @(posedge clk); #1;
        a.arvalid = 1'b0;
        ld_we = 1'b0;
    endtask

    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input int nbeats);
        @(posedge clk); #1;
        a.wvalid = 1'b1; a.wlast = 1'b1; a.wdata = $urandom;
        @(negedge clk);
        chk("wready_before_aw", 64'(wr), 64'd0);
        @(posedge clk); #1;
        a.wvalid = 1'b0; a.wlast = 1'b0;
        a.awid = id; a.awaddr = addr; a.awlen = 4'(nbeats - 1); a.awburst = BURST_INCR; a.awsize = 3'b010;
        a.awvalid = 1'b1; a.bready = 1'b0;
        bq0.push_back(id);
        bq1.push_back(id);
        @(posedge clk); #1;
        a.awvalid = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            a.wvalid = 1'b1; a.wlast = (i == nbeats - 1); a.wdata = $urandom; a.wstrb = 4'hF;
            a.wid = 4'($urandom);
            @(negedge clk);
            chk("wready_data", 64'(wr), 64'd3);
            @(posedge clk); #1;
        end
        a.wvalid = 1'b0; a.wlast = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bvalid_hold", 64'({bv, bi[0], bi[1], br[0], br[1]}), 64'({2'b11, id, id, RESP_SLVERR, RESP_SLVERR}));
            @(posedge clk); #1;
        end
        a.bready = 1'b1;
    endtask

    initial begin
        a.arid = '0; a.araddr = '0; a.arlen = '0; a.arsize = 3'b010; a.arburst = BURST_INCR;
        a.arlock = '0; a.arcache = '0; a.arprot = '0; a.arvalid = 1'b0; a.rready = 1'b1;
        a.awid = '0; a.awaddr = '0; a.awlen = '0; a.awsize = '0; a.awburst = '0;
        a.awlock = '0; a.awcache = '0; a.awprot = '0; a.awvalid = 1'b0;
        a.wid = '0; a.wdata = '0; a.wstrb = '0; a.wlast = 1'b0; a.wvalid = 1'b0; a.bready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_rdata", 64'({rd[1], rd[0]}), 64'd0);
        chk("reset_rctl", 64'({rv, rl, rr[0], rr[1], ri[0], ri[1]}), 64'd0);
        chk("reset_wctl", 64'({wr, bv, br[0], br[1], bi[0], bi[1]}), 64'd0);
        chk("reset_ready", 64'({arr, awr}), 64'hF);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < DEPTH; i++) load(i, $urandom);
        load(4, 32'h2400_0001);

        do_read(4'd5, 32'hBFC0_0010, 4'd0, BURST_INCR, 3'b010);
        rr_mode = 1;
        do_read(4'd3, 32'h1FC0_0000, 4'd7, BURST_INCR, 3'b010);
        wait_idle();
        rr_mode = 0;
        do_read(4'd2, 32'((DEPTH - 2) * 4), 4'd3, BURST_INCR, 3'b010);
        do_read(4'd6, 32'h0000_0014, 4'd3, BURST_FIXED, 3'b010);
        do_read(4'd7, 32'h0000_0040, 4'd0, BURST_INCR, 3'b001);
        wait_idle();

        fork
            do_write(4'd9, 32'h0000_0100, 2);
            do_read(4'd1, 32'h0000_0100, 4'd7, BURST_INCR, 3'b010);
        join
        wait_idle();
        do_read(4'd4, 32'h0000_0100, 4'd1, BURST_INCR, 3'b010);
        do_read_collide(4'd8, 12, 32'hCAFE_F00D);
        wait_idle();

        rr_mode = 2;
        for (int n = 0; n < 25; n++) begin
            if (n % 5 == 0) begin
                wait_idle();
                load($urandom_range(0, DEPTH - 1), $urandom);
            end
            do_read(4'($urandom), $urandom, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                    ($urandom_range(0, 3) == 0) ? 3'b001 : 3'b010);
        end
        wait_idle();

        rr_mode = 0;
        do_read(4'd11, 32'h0000_0200, 4'd7, BURST_INCR, 3'b010);
        for (int t = 0; t < 200 && q0.size() > 5; t++) @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_rvalid", 64'({rv, bv}), 64'd0);
        chk("abort_ready", 64'({arr, awr}), 64'hF);
        q0.delete(); q1.delete();
        first_pend[0] = 1'b0; first_pend[1] = 1'b0;
        stalled[0] = 1'b0; stalled[1] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_idle", 64'({arr, rv}), 64'hC);
        do_read(4'd12, 32'h0000_0208, 4'd0, BURST_INCR, 3'b010);
        wait_idle();
        repeat (3) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
